// File: rtl/glyph_raster_pkg.sv
// Shared constants, state encoding and address helper for the glyph rectangle rasteriser.
package glyph_raster_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int ADDR_W   = 19;
    localparam int COLOR_W  = 8;
    localparam int COORD_W  = 32;
    localparam int POS_W    = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // y*640 as (y<<9)+(y<<7); only used once per rectangle, never per pixel.
    function automatic logic [ADDR_W-1:0] row_base(input logic [POS_W-1:0] y);
        logic [ADDR_W-1:0] yw;
        yw = {{(ADDR_W-POS_W){1'b0}}, y};
        return (yw << 9) + (yw << 7);
    endfunction

endpackage

// File: rtl/glyph_raster_rect_clip.sv
// Clips the exclusive bottom-right corner to the screen and flags rectangles with no visible pixels.
module rect_clip
    import glyph_raster_pkg::*;
(
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic [COORD_W-1:0] x2,
    input  logic [COORD_W-1:0] y2,
    output logic [POS_W-1:0]   xe,
    output logic [POS_W-1:0]   ye,
    output logic               empty
);

    localparam logic [COORD_W-1:0] W32 = COORD_W'(SCREEN_W);
    localparam logic [COORD_W-1:0] H32 = COORD_W'(SCREEN_H);

    always_comb begin
        xe    = (x2 < W32) ? x2[POS_W-1:0] : POS_W'(SCREEN_W);
        ye    = (y2 < H32) ? y2[POS_W-1:0] : POS_W'(SCREEN_H);
        empty = (x1 >= COORD_W'(xe)) || (y1 >= COORD_W'(ye));
    end

endmodule

// File: rtl/glyph_raster.sv
// Rectangle fill rasteriser: accepts one rectangle, streams clipped row-major framebuffer writes.
// Handshakes: a transfer happens on a rising clock edge where valid & ready are both 1; while
// valid is 1 and ready is 0 the source holds its payload stable.
module glyph_raster
    import glyph_raster_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COORD_W-1:0] in_x1,
    input  logic [COORD_W-1:0] in_y1,
    input  logic [COORD_W-1:0] in_x2,
    input  logic [COORD_W-1:0] in_y2,
    input  logic [COLOR_W-1:0] in_color,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_addr,
    output logic [COLOR_W-1:0] out_color,
    output logic               out_last,
    output logic               done,
    output state_t             dbg_state
);

    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(SCREEN_W);

    state_t               state_q, state_d;
    logic [COORD_W-1:0]   x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic [COLOR_W-1:0]   color_q, color_d;
    logic [POS_W-1:0]     xe_q, xe_d, ye_q, ye_d;
    logic [POS_W-1:0]     x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0]    row_q, row_d, addr_q, addr_d;

    logic [POS_W-1:0]     clip_xe, clip_ye;
    logic                 clip_empty;
    logic                 fire, row_end, last_row;
    logic [ADDR_W-1:0]    x1_addr, load_row;

    rect_clip u_clip (
        .x1    (x1_q),
        .y1    (y1_q),
        .x2    (x2_q),
        .y2    (y2_q),
        .xe    (clip_xe),
        .ye    (clip_ye),
        .empty (clip_empty)
    );

    assign fire     = out_valid & out_ready;
    assign row_end  = (x_q == xe_q - POS_W'(1));
    assign last_row = (y_q == ye_q - POS_W'(1));
    assign x1_addr  = {{(ADDR_W-POS_W){1'b0}}, x1_q[POS_W-1:0]};
    assign load_row = row_base(y1_q[POS_W-1:0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x1_q    <= '0;
            y1_q    <= '0;
            x2_q    <= '0;
            y2_q    <= '0;
            color_q <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            row_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            x2_q    <= x2_d;
            y2_q    <= y2_d;
            color_q <= color_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            x_q     <= x_d;
            y_q     <= y_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_LOAD;
            ST_LOAD: state_d = clip_empty ? ST_DONE : ST_RUN;
            ST_RUN:  if (fire && row_end && last_row) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !reset;
        out_valid = (state_q == ST_RUN);
        out_last  = (state_q == ST_RUN) && row_end && last_row;
        done      = (state_q == ST_DONE);
        out_addr  = addr_q;
        out_color = color_q;
        dbg_state = state_q;
    end

    always_comb begin
        x1_d    = x1_q;
        y1_d    = y1_q;
        x2_d    = x2_q;
        y2_d    = y2_q;
        color_d = color_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        x_d     = x_q;
        y_d     = y_q;
        row_d   = row_q;
        addr_d  = addr_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    x1_d    = in_x1;
                    y1_d    = in_y1;
                    x2_d    = in_x2;
                    y2_d    = in_y2;
                    color_d = in_color;
                end
            end
            ST_LOAD: begin
                // Counter values are garbage for empty rectangles but are never emitted.
                xe_d   = clip_xe;
                ye_d   = clip_ye;
                x_d    = x1_q[POS_W-1:0];
                y_d    = y1_q[POS_W-1:0];
                row_d  = load_row;
                addr_d = load_row + x1_addr;
            end
            ST_RUN: begin
                if (fire) begin
                    if (row_end) begin
                        x_d    = x1_q[POS_W-1:0];
                        y_d    = y_q + POS_W'(1);
                        row_d  = row_q + ROW_STEP;
                        addr_d = row_q + ROW_STEP + x1_addr;
                    end else begin
                        x_d    = x_q + POS_W'(1);
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_glyph_raster.sv
// Randomised and directed bench for glyph_raster with a queue-based scoreboard and stall monitor.
module tb_glyph_raster;
    import glyph_raster_pkg::*;

    logic               clock = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        in_x1, in_y1, in_x2, in_y2;
    logic [7:0]         in_color;
    logic               out_valid;
    logic               out_ready;
    logic [18:0]        out_addr;
    logic [7:0]         out_color;
    logic               out_last;
    logic               done;
    state_t             dbg_state;

    int checks = 0;
    int failures = 0;
    int beats_seen = 0;
    int exp_done_cnt = 0;
    int rdy_mode = 0;
    int cyc = 0;

    logic [27:0] exp_q[$];

    logic        prev_stall = 1'b0;
    logic [27:0] prev_beat = '0;
    logic        prev_done = 1'b0;

    glyph_raster dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x1     (in_x1),
        .in_y1     (in_y1),
        .in_x2     (in_x2),
        .in_y2     (in_y2),
        .in_color  (in_color),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_color (out_color),
        .out_last  (out_last),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: every on-screen pixel of [x1,x2)x[y1,y2) in row-major order.
    task automatic model_rect(input logic [31:0] x1, y1, x2, y2, input logic [7:0] color,
                              output int n);
        longint xe, ye;
        xe = (longint'(x2) > SCREEN_W) ? SCREEN_W : longint'(x2);
        ye = (longint'(y2) > SCREEN_H) ? SCREEN_H : longint'(y2);
        n = 0;
        for (longint y = longint'(y1); y < ye; y++) begin
            for (longint x = longint'(x1); x < xe; x++) begin
                logic [18:0] a;
                logic        l;
                a = 19'(y * SCREEN_W + x);
                l = (x == xe - 1) && (y == ye - 1);
                exp_q.push_back({l, color, a});
                n++;
            end
        end
    endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_beat_held", {out_last, out_color, out_addr}, prev_beat);
            end
            if (out_valid && out_ready) begin
                beats_seen++;
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 1, 0);
                end else begin
                    logic [27:0] e;
                    e = exp_q.pop_front();
                    check("beat_addr", out_addr, e[18:0]);
                    check("beat_color", out_color, e[26:19]);
                    check("beat_last", out_last, e[27]);
                end
            end
            if (done) begin
                check("done_expected", (exp_done_cnt > 0) ? 1 : 0, 1);
                check("done_after_all_beats", exp_q.size(), 0);
                check("done_one_cycle", prev_done, 0);
                check("done_no_valid", out_valid, 0);
                if (exp_done_cnt > 0) exp_done_cnt--;
            end
            prev_stall = out_valid && !out_ready;
            prev_beat  = {out_last, out_color, out_addr};
            prev_done  = done;
        end
    end

    // driver: issue one rectangle, check acceptance and first-response latency
    task automatic send_rect(input logic [31:0] x1, y1, x2, y2, input logic [7:0] color);
        int n;
        int budget;
        model_rect(x1, y1, x2, y2, color, n);
        exp_done_cnt++;
        budget = 0;
        while (!in_ready && budget < 20000) begin
            @(posedge clock); #1;
            budget++;
        end
        check("in_ready_before_req", in_ready, 1);
        in_valid = 1'b1;
        in_x1 = x1; in_y1 = y1; in_x2 = x2; in_y2 = y2; in_color = color;
        @(posedge clock); #1;
        // Accept edge passed: block is in LOAD, keep in_valid high with garbage to prove it is ignored.
        check("in_ready_after_accept", in_ready, 0);
        check("load_quiet", {out_valid, done}, 0);
        in_x1 = $urandom; in_y1 = $urandom; in_x2 = $urandom; in_y2 = $urandom;
        in_color = 8'($urandom);
        @(posedge clock); #1;
        in_valid = 1'b0;
        check("first_response", (n > 0) ? out_valid : done, 1);
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while ((exp_done_cnt != 0 || dbg_state != ST_IDLE) && budget < 20000) begin
            @(posedge clock); #1;
            budget++;
        end
        check("complete_in_budget", (budget < 20000) ? 1 : 0, 1);
    endtask

    task automatic run_rect(input string name, input logic [31:0] x1, y1, x2, y2,
                            input logic [7:0] color, input int want_beats);
        int start;
        start = beats_seen;
        send_rect(x1, y1, x2, y2, color);
        wait_idle();
        if (want_beats >= 0) check(name, beats_seen - start, want_beats);
    endtask

    initial begin
        int start;
        int budget;
        reset = 1'b1;
        in_valid = 1'b0;
        in_x1 = '0; in_y1 = '0; in_x2 = '0; in_y2 = '0; in_color = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_out_addr", out_addr, 0);
        check("rst_out_color", out_color, 0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_rst", in_ready, 1);

        run_rect("basic_beats", 100, 50, 132, 146, 8'h5a, 3072);
        run_rect("degenerate_beats", 10, 10, 10, 42, 8'h11, 0);
        run_rect("clip_beats", 620, 470, 652, 502, 8'h22, 200);
        run_rect("offscreen_beats", 700, 10, 732, 42, 8'h33, 0);
        run_rect("single_beats", 0, 0, 1, 1, 8'h44, 1);
        run_rect("huge_clip_beats", 639, 479, 32'hffff_ffff, 32'hffff_fff0, 8'h55, 1);
        run_rect("below_beats", 5, 480, 40, 500, 8'h66, 0);

        rdy_mode = 1;
        run_rect("toggle_beats", 100, 50, 132, 146, 8'h77, 3072);

        rdy_mode = 2;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] x1, y1;
            x1 = 32'($urandom_range(0, 660));
            y1 = 32'($urandom_range(0, 490));
            run_rect("rand_rect", x1, y1, x1 + 32'($urandom_range(0, 40)),
                     y1 + 32'($urandom_range(0, 20)), 8'($urandom), -1);
        end

        // reset in the middle of a rectangle
        rdy_mode = 0;
        start = beats_seen;
        send_rect(100, 50, 132, 146, 8'h99);
        budget = 0;
        while (beats_seen - start < 500 && budget < 5000) begin
            @(negedge clock);
            budget++;
        end
        check("reach_beat_500", beats_seen - start, 500);
        @(posedge clock); #2;
        reset = 1'b1;
        #1;
        check("midrun_rst_valid", out_valid, 0);
        check("midrun_rst_done", done, 0);
        exp_q.delete();
        exp_done_cnt = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        check("in_ready_after_midrun_rst", in_ready, 1);
        repeat (4) @(posedge clock);
        #1;
        check("no_done_after_midrun_rst", done, 0);
        run_rect("post_rst_beats", 300, 200, 316, 208, 8'hc3, 128);

        repeat (5) @(posedge clock);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
